// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   scan_state_t : scanner state (SCAN / DEBOUNCE / PRESSED)
//   KEY_A..KEY_HASH : values of the non-digit keys
//   KEY_MAP      : key value indexed by {row, col}
//   lowest_row() : index of the lowest set bit of a pressed-row mask
//   col_sel_n()  : active-low one-hot column drive for a column index
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Row-major layout, index 15 first:  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  localparam logic [15:0][3:0] KEY_MAP = {
    KEY_D, KEY_HASH, 4'd0, KEY_STAR,
    KEY_C, 4'd9,     4'd8, 4'd7,
    KEY_B, 4'd6,     4'd5, 4'd4,
    KEY_A, 4'd3,     4'd2, 4'd1
  };

  // Lowest pressed row wins when several rows read low in one column.
  function automatic logic [1:0] lowest_row(input logic [3:0] mask);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] col_sel_n(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// sync2: 4-bit two-flop synchronizer for the asynchronous row lines.
//   clk, rts : clock, synchronous active-high reset (flops reset to 4'hF = idle rows)
//   d        : asynchronous input
//   q        : synchronized output
module sync2 (
  input  logic       clk,
  input  logic       rts,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (rts) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low key matrix and emits debounced key codes.
//   clk       : system clock
//   rts       : synchronous active-high reset
//   Col_drive : active-low one-hot column drive (4'b1110 = column 0)
//   Row_in    : raw active-low row lines (asynchronous)
//   key_code  : mapped value of the last accepted key
//   key_valid : one-cycle pulse on press acceptance
//   key_held  : high from acceptance until release is accepted
//   Entry     : four-digit BCD accumulator, only when KEYPAD_ACCUM_EN is defined
// Parameters: SCAN_DIV clk cycles per column slot (>= 4), DEB_CNT matching samples (1..15).
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEB_CNT  = 4
) (
  input  logic        clk,
  input  logic        rts,
  output logic [3:0]  Col_drive,
  input  logic [3:0]  Row_in,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
`ifdef KEYPAD_ACCUM_EN
  ,
  output logic [15:0] Entry
`endif
);

  localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_LAST   = 4'(DEB_CNT);

  scan_state_t   state;
  logic [TW-1:0] timer;
  logic [1:0]    col;
  logic [3:0]    mask_q;
  logic [3:0]    deb;
  logic [3:0]    rel;
  logic [3:0]    sync_row;

  logic          sample;
  logic [3:0]    m;
  logic [1:0]    col_next;
  logic [3:0]    deb_inc;
  logic [3:0]    rel_inc;
  logic [3:0]    hit_code;
  logic          accept;

  sync2 u_sync (
    .clk (clk),
    .rts (rts),
    .d   (Row_in),
    .q   (sync_row)
  );

  // Sample strobe, pressed mask and the value of the key under the current column.
  always_comb begin
    sample   = (timer == TIMER_LAST);
    m        = ~sync_row;
    col_next = col + 2'd1;
    deb_inc  = deb + 4'd1;
    rel_inc  = rel + 4'd1;
    hit_code = KEY_MAP[{lowest_row(m), col}];
    accept   = 1'b0;
    if (sample) begin
      case (state)
        SCAN:     accept = (m != 4'd0) && (DEB_LAST == 4'd1);
        DEBOUNCE: accept = (m == mask_q) && (deb_inc == DEB_LAST);
        default:  accept = 1'b0;
      endcase
    end
  end

  // Slot timer, scan FSM and registered key outputs.
  always_ff @(posedge clk) begin
    if (rts) begin
      state     <= SCAN;
      timer     <= '0;
      col       <= 2'd0;
      Col_drive <= 4'b1110;
      mask_q    <= 4'd0;
      deb       <= 4'd0;
      rel       <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      timer     <= sample ? '0 : timer + TW'(1);

      if (accept) begin
        key_code  <= hit_code;
        key_valid <= 1'b1;
        key_held  <= 1'b1;
      end

      if (sample) begin
        case (state)
          SCAN: begin
            if (m == 4'd0) begin
              col       <= col_next;
              Col_drive <= col_sel_n(col_next);
            end else begin
              // Column freezes here until the press is rejected or released.
              mask_q <= m;
              deb    <= accept ? 4'd0 : 4'd1;
              state  <= accept ? PRESSED : DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (m == mask_q) begin
              deb <= accept ? 4'd0 : deb_inc;
              if (accept) state <= PRESSED;
            end else begin
              state     <= SCAN;
              deb       <= 4'd0;
              col       <= col_next;
              Col_drive <= col_sel_n(col_next);
            end
          end
          PRESSED: begin
            // Row changes while held only restart the release count.
            if (m == 4'd0) begin
              if (rel_inc == DEB_LAST) begin
                state     <= SCAN;
                rel       <= 4'd0;
                key_held  <= 1'b0;
                col       <= col_next;
                Col_drive <= col_sel_n(col_next);
              end else begin
                rel <= rel_inc;
              end
            end else begin
              rel <= 4'd0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

`ifdef KEYPAD_ACCUM_EN
  // Digit accumulator: digits shift in, '*' clears, other keys are ignored.
  always_ff @(posedge clk) begin
    if (rts) begin
      Entry <= 16'd0;
    end else if (accept) begin
      if (hit_code <= 4'd9) begin
        Entry <= {Entry[11:0], hit_code};
      end else if (hit_code == KEY_STAR) begin
        Entry <= 16'd0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: self-checking bench for keypad_scan (SCAN_DIV=4, DEB_CNT=3).
// A keypad model turns pressed keys into row levels from the live column drive;
// a sample-level reference model predicts every output each cycle.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB_CNT  = 3;

  logic        clk = 1'b0;
  logic        rts = 1'b1;
  logic [3:0]  Col_drive;
  logic [3:0]  Row_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
`ifdef KEYPAD_ACCUM_EN
  logic [15:0] Entry;
`endif

  logic [3:0]  keys [4];   // keys[row][col] = 1 when that key is held down
  int          checks = 0;
  int          passed = 0;
  logic        model_on = 1'b0;
  int          valid_cnt = 0;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)) dut (
    .clk       (clk),
    .rts       (rts),
    .Col_drive (Col_drive),
    .Row_in    (Row_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
`ifdef KEYPAD_ACCUM_EN
    ,
    .Entry     (Entry)
`endif
  );

  // A row reads low when any pressed key on it sits in a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) Row_in[r] = ~|(keys[r] & ~Col_drive);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  string       layout = "123A456B789C*0#D";
  int          m_mode;     // 0 scanning, 1 confirming a press, 2 key held
  int          m_col, m_streak, m_quiet, m_cyc;
  logic [3:0]  m_cand, m_code, h1, h2, mk, exp_col;
  logic        m_valid, m_held;
  logic [15:0] m_entry;

  function automatic logic [3:0] key_value(input int r, input int c);
    byte ch;
    ch = layout[r*4 + c];
    if (ch >= "0" && ch <= "9") return 4'(ch - 8'd48);
    case (ch)
      "A":     return 4'd10;
      "B":     return 4'd11;
      "C":     return 4'd12;
      "D":     return 4'd13;
      "*":     return 4'd14;
      default: return 4'd15;
    endcase
  endfunction

  function automatic int lowest(input logic [3:0] mask);
    for (int r = 0; r < 4; r++) if (mask[r]) return r;
    return 0;
  endfunction

  task model_accept();
    m_code  = key_value(lowest(m_cand), m_col);
    m_valid = 1'b1;
    m_held  = 1'b1;
    m_mode  = 2;
    m_quiet = 0;
    if (m_code <= 4'd9) m_entry = {m_entry[11:0], m_code};
    else if (m_code == 4'd14) m_entry = 16'd0;
  endtask

  always @(posedge clk) begin
    if (rts) begin
      m_mode = 0; m_col = 0; m_streak = 0; m_quiet = 0; m_cyc = 0;
      m_cand = 4'd0; m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0; m_entry = 16'd0;
      h1 = 4'hF; h2 = 4'hF;
    end else begin
      m_valid = 1'b0;
      mk = ~h2;
      if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
        if (m_mode == 0) begin
          if (mk == 4'd0) m_col = (m_col + 1) % 4;
          else begin
            m_cand = mk; m_streak = 1; m_mode = 1;
            if (m_streak == DEB_CNT) model_accept();
          end
        end else if (m_mode == 1) begin
          if (mk == m_cand) begin
            m_streak++;
            if (m_streak == DEB_CNT) model_accept();
          end else begin
            m_mode = 0; m_col = (m_col + 1) % 4;
          end
        end else begin
          if (mk == 4'd0) begin
            m_quiet++;
            if (m_quiet == DEB_CNT) begin
              m_mode = 0; m_held = 1'b0; m_quiet = 0; m_col = (m_col + 1) % 4;
            end
          end else m_quiet = 0;
        end
      end
      m_cyc++;
      h2 = h1;
      h1 = Row_in;
    end
  end

  always @(posedge clk) if (key_valid) valid_cnt++;

  always @(negedge clk) begin
    if (model_on) begin
      exp_col = 4'b0001 << m_col;
      exp_col = ~exp_col;
      check("model_col_drive", 32'(Col_drive), 32'(exp_col));
      check("model_key_valid", 32'(key_valid), 32'(m_valid));
      check("model_key_held",  32'(key_held),  32'(m_held));
      check("model_key_code",  32'(key_code),  32'(m_code));
`ifdef KEYPAD_ACCUM_EN
      check("model_entry",     32'(Entry),     32'(m_entry));
`endif
      if (key_valid) check("valid_one_cycle", 32'(prev_valid), 32'd0);
    end
    prev_valid = key_valid;
  end

  // ---------------- helpers ----------------
  task automatic wait_valid(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (key_valid) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_release(input string name, input int budget, output int lat);
    logic ok;
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (!key_held) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_col(input logic [3:0] val, input int budget);
    logic ok;
    ok = (Col_drive == val);
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (Col_drive == val) ok = 1'b1;
    end
    check("wait_col_drive", 32'(ok), 32'd1);
  endtask

  task automatic press_release(input int r, input int c, input logic [3:0] code, input string name);
    int lat;
    keys[r][c] = 1'b1;
    wait_valid({name, "_valid"}, 100);
    check({name, "_code"}, 32'(key_code), 32'(code));
    check({name, "_held"}, 32'(key_held), 32'd1);
    keys[r][c] = 1'b0;
    wait_release({name, "_release"}, 100, lat);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } key_vec_t;

  key_vec_t vecs [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] steps [4];
    int         lat;
    int         snap;

    vecs = '{'{0, 0, 4'd1},  '{0, 1, 4'd2},  '{0, 2, 4'd3},  '{0, 3, 4'd10},
             '{1, 0, 4'd4},  '{1, 1, 4'd5},  '{1, 2, 4'd6},  '{1, 3, 4'd11},
             '{2, 0, 4'd7},  '{2, 1, 4'd8},  '{2, 2, 4'd9},  '{2, 3, 4'd12},
             '{3, 0, 4'd14}, '{3, 1, 4'd0},  '{3, 2, 4'd15}, '{3, 3, 4'd13}};
    steps = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int r = 0; r < 4; r++) keys[r] = 4'd0;

    // Reset state
    rts = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col_drive", 32'(Col_drive), 32'hE);
    check("rst_key_code",  32'(key_code),  32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_held",  32'(key_held),  32'd0);
`ifdef KEYPAD_ACCUM_EN
    check("rst_entry",     32'(Entry),     32'd0);
`endif
    model_on = 1'b1;
    rts = 1'b0;

    // Column stepping with no key pressed
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) check("col_step_first", 32'(Col_drive), 32'hE);
      if (n % 4 == 0) check("col_step", 32'(Col_drive), 32'(steps[n/4 - 1]));
    end

    // Single press: key 6 (row 1, column 2)
    snap = valid_cnt;
    keys[1][2] = 1'b1;
    wait_valid("single_valid", 100);
    check("single_code", 32'(key_code), 32'd6);
    @(negedge clk);
    check("single_pulse_low", 32'(key_valid), 32'd0);
    check("single_held", 32'(key_held), 32'd1);
    repeat (20) @(negedge clk);
    check("single_one_pulse", 32'(valid_cnt - snap), 32'd1);
    keys[1][2] = 1'b0;
    wait_release("single_release", 100, lat);
    check("single_release_latency", 32'(lat >= 10 && lat <= 15), 32'd1);
    repeat (3) @(negedge clk);

    // Every key once, table-driven
    foreach (vecs[i]) press_release(vecs[i].row, vecs[i].col, vecs[i].code, $sformatf("map%0d", i));

    // Bounce reject in column 0
    wait_col(4'b0111, 40);
    wait_col(4'b1110, 40);
    snap = valid_cnt;
    keys[0][0] = 1'b1;
    repeat (4) @(negedge clk);
    check("bounce_col_frozen", 32'(Col_drive), 32'hE);
    keys[0][0] = 1'b0;
    repeat (4) @(negedge clk);
    check("bounce_col_advanced", 32'(Col_drive), 32'hD);
    keys[0][0] = 1'b1;
    repeat (4) @(negedge clk);
    keys[0][0] = 1'b0;
    repeat (4) @(negedge clk);
    check("bounce_no_valid", 32'(valid_cnt - snap), 32'd0);
    check("bounce_not_held", 32'(key_held), 32'd0);

    // Simultaneous keys in column 1, then a key elsewhere while held
    keys[0][1] = 1'b1;
    keys[3][1] = 1'b1;
    wait_valid("simul_valid", 100);
    check("simul_code", 32'(key_code), 32'd2);
    keys[2][3] = 1'b1;
    repeat (2) @(negedge clk);
    snap = valid_cnt;
    repeat (40) @(negedge clk);
    check("simul_no_second_valid", 32'(valid_cnt - snap), 32'd0);
    check("simul_still_held", 32'(key_held), 32'd1);
    check("simul_code_kept", 32'(key_code), 32'd2);
    keys[0][1] = 1'b0;
    keys[3][1] = 1'b0;
    keys[2][3] = 1'b0;
    wait_release("simul_release", 100, lat);
    repeat (3) @(negedge clk);

    // Reset after two matching samples in column 2
    wait_col(4'b1101, 40);
    wait_col(4'b1011, 40);
    snap = valid_cnt;
    keys[0][2] = 1'b1;
    repeat (8) @(negedge clk);
    rts = 1'b1;
    @(negedge clk);
    check("rstmid_col_drive", 32'(Col_drive), 32'hE);
    check("rstmid_key_valid", 32'(key_valid), 32'd0);
    check("rstmid_key_held",  32'(key_held),  32'd0);
    rts = 1'b0;
    keys[0][2] = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_no_valid", 32'(valid_cnt - snap), 32'd0);

`ifdef KEYPAD_ACCUM_EN
    // Accumulator
    press_release(0, 0, 4'd1, "acc1");
    press_release(0, 1, 4'd2, "acc2");
    press_release(0, 2, 4'd3, "acc3");
    press_release(1, 0, 4'd4, "acc4");
    press_release(1, 1, 4'd5, "acc5");
    check("acc_entry_2345", 32'(Entry), 32'h2345);
    press_release(3, 0, 4'd14, "acc_star");
    check("acc_entry_clear", 32'(Entry), 32'h0);
    press_release(0, 3, 4'd10, "acc_a0");
    check("acc_entry_a_zero", 32'(Entry), 32'h0);
    press_release(2, 0, 4'd7, "acc7");
    press_release(0, 3, 4'd10, "acc_a7");
    check("acc_entry_a_keep", 32'(Entry), 32'h7);
`endif

    // Randomized presses, bounces and overlapping keys against the model
    for (int it = 0; it < 40; it++) begin
      int nk;
      nk = int'($urandom_range(1, 2));
      for (int k = 0; k < nk; k++) keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      repeat ($urandom_range(1, 60)) @(negedge clk);
      for (int r = 0; r < 4; r++) keys[r] = 4'd0;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
